// File: rtl/argmax_classifier.sv
// Argmax output stage: drains the output layer's serial results, tracks the
// signed maximum and its class index, hands the result over with valid/ack,
// then requests a layer restart for the next inference.
module argmax_classifier #(
  parameter int DATA_WIDTH  = 38,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  layer_done,
  input  logic                  layer_transferred,
  input  logic [DATA_WIDTH-1:0] layer_sout,
  output logic                  shift_req,
  output logic                  restart_req,
  output logic                  result_valid,
  input  logic                  result_ack,
  output logic [IDX_WIDTH-1:0]  class_idx,
  output logic [DATA_WIDTH-1:0] max_value,
  output logic                  busy,
  output logic                  protocol_err
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    DRAIN,
    CHECK,
    RESULT,
    RESTART
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

  state_t                       state;
  logic [IDX_WIDTH-1:0]         issue_cnt;
  logic [IDX_WIDTH-1:0]         cap_cnt;
  logic [IDX_WIDTH-1:0]         run_idx;
  logic signed [DATA_WIDTH-1:0] run_max;
  logic                         cap_valid;
  logic                         start;

  assign start = (state == IDLE) && layer_done && !layer_transferred;
  assign busy  = (state != IDLE);

  // Control FSM: strobe sequencing, result handshake, restart and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      shift_req    <= 1'b0;
      restart_req  <= 1'b0;
      result_valid <= 1'b0;
      class_idx    <= '0;
      max_value    <= '0;
      protocol_err <= 1'b0;
      issue_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SHIFT;
            shift_req <= 1'b1;
            issue_cnt <= '0;
          end
        end
        SHIFT: begin
          if (layer_transferred && (issue_cnt < LAST_IDX)) begin
            protocol_err <= 1'b1;
          end
          issue_cnt <= issue_cnt + 1'b1;
          if (issue_cnt == LAST_IDX) begin
            shift_req <= 1'b0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          state <= CHECK;
        end
        CHECK: begin
          if (!layer_transferred) begin
            protocol_err <= 1'b1;
          end
          class_idx    <= run_idx;
          max_value    <= run_max;
          result_valid <= 1'b1;
          state        <= RESULT;
        end
        RESULT: begin
          if (result_ack) begin
            result_valid <= 1'b0;
            restart_req  <= 1'b1;
            state        <= RESTART;
          end
        end
        RESTART: begin
          if (!layer_transferred) begin
            restart_req <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Capture path: one word per delayed strobe, strict signed running maximum
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid <= 1'b0;
      cap_cnt   <= '0;
      run_max   <= '0;
      run_idx   <= '0;
    end else begin
      cap_valid <= shift_req;
      if (cap_valid) begin
        if ((cap_cnt == '0) || ($signed(layer_sout) > run_max)) begin
          run_max <= $signed(layer_sout);
          run_idx <= cap_cnt;
        end
        cap_cnt <= cap_cnt + 1'b1;
      end
      if (start) begin
        cap_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_argmax_classifier.sv
// Self-checking bench for argmax_classifier with a behavioural upstream layer.
module tb_argmax_classifier;

  localparam int DW = 38;
  localparam int NC = 10;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          layer_done;
  logic          layer_transferred;
  logic [DW-1:0] layer_sout;
  logic          shift_req;
  logic          restart_req;
  logic          result_valid;
  logic          result_ack;
  logic [IW-1:0] class_idx;
  logic [DW-1:0] max_value;
  logic          busy;
  logic          protocol_err;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] words [NC];
  int            wk;
  bit            pend;
  int            shift_cnt;
  bit            auto_xfer = 1'b1;

  argmax_classifier #(
    .DATA_WIDTH (DW),
    .NUM_CLASSES(NC),
    .IDX_WIDTH  (IW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .layer_done       (layer_done),
    .layer_transferred(layer_transferred),
    .layer_sout       (layer_sout),
    .shift_req        (shift_req),
    .restart_req      (restart_req),
    .result_valid     (result_valid),
    .result_ack       (result_ack),
    .class_idx        (class_idx),
    .max_value        (max_value),
    .busy             (busy),
    .protocol_err     (protocol_err)
  );

  always #5 clk = ~clk;

  // Upstream layer: updates on falling edge, word for strobe n appears in cycle n+1
  task automatic upstream();
    forever begin
      @(negedge clk);
      if (pend) begin
        if (wk < NC) layer_sout = words[wk];
        wk++;
        if (wk == NC && auto_xfer) layer_transferred = 1'b1;
      end
      pend = shift_req;
      if (shift_req) shift_cnt++;
      if (restart_req) begin
        layer_transferred = 1'b0;
        layer_done        = 1'b0;
      end
    end
  endtask

  function automatic logic [DW-1:0] int2fx(input int v);
    logic signed [DW-1:0] t;
    t = DW'(v);
    return t <<< 28;
  endfunction

  // Reference: first index holding the largest signed value
  function automatic void ref_argmax(output int idx, output logic [DW-1:0] val);
    idx = 0;
    for (int i = 1; i < NC; i++)
      if ($signed(words[i]) > $signed(words[idx])) idx = i;
    val = words[idx];
  endfunction

  task automatic run_inference(input string name, input bit exp_perr, input int hold);
    int            lat;
    int            exp_idx;
    logic [DW-1:0] exp_val;
    bit            seen;
    ref_argmax(exp_idx, exp_val);
    wk = 0; pend = 1'b0; shift_cnt = 0;
    layer_transferred = 1'b0;
    layer_done = 1'b1;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (result_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || lat != NC + 3) begin
      failures++;
      $display("FAIL %s latency: got %0d cycles (seen=%0b) expected %0d", name, lat, seen, NC + 3);
    end
    checks++;
    if (class_idx !== IW'(exp_idx)) begin
      failures++;
      $display("FAIL %s class_idx: got %0d expected %0d", name, class_idx, exp_idx);
    end
    checks++;
    if (max_value !== exp_val) begin
      failures++;
      $display("FAIL %s max_value: got %h expected %h", name, max_value, exp_val);
    end
    checks++;
    if (shift_cnt != NC) begin
      failures++;
      $display("FAIL %s shift_count: got %0d expected %0d", name, shift_cnt, NC);
    end
    checks++;
    if (protocol_err !== exp_perr) begin
      failures++;
      $display("FAIL %s protocol_err: got %b expected %b", name, protocol_err, exp_perr);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (result_valid !== 1'b1 || class_idx !== IW'(exp_idx) || max_value !== exp_val ||
          shift_req !== 1'b0 || restart_req !== 1'b0) begin
        failures++;
        $display("FAIL %s hold cycle %0d: valid=%b idx=%0d max=%h shift=%b restart=%b expected valid=1 idx=%0d max=%h shift=0 restart=0",
                 name, i, result_valid, class_idx, max_value, shift_req, restart_req, exp_idx, exp_val);
      end
    end
    result_ack = 1'b1;
    @(posedge clk); #1;
    result_ack = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || restart_req !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s after_ack: valid=%b restart=%b busy=%b expected 0 1 1", name, result_valid, restart_req, busy);
    end
    lat = 0;
    while (busy !== 1'b0 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (busy !== 1'b0 || restart_req !== 1'b0) begin
      failures++;
      $display("FAIL %s restart_done: busy=%b restart=%b expected 0 0", name, busy, restart_req);
    end
    checks++;
    if (class_idx !== IW'(exp_idx) || max_value !== exp_val) begin
      failures++;
      $display("FAIL %s retained: idx=%0d max=%h expected idx=%0d max=%h", name, class_idx, max_value, exp_idx, exp_val);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    checks++;
    if (shift_req !== 0 || restart_req !== 0 || result_valid !== 0 || class_idx !== '0 ||
        max_value !== '0 || busy !== 0 || protocol_err !== 0) begin
      failures++;
      $display("FAIL reset_state: shift=%b restart=%b valid=%b idx=%0d max=%h busy=%b perr=%b expected all 0",
               shift_req, restart_req, result_valid, class_idx, max_value, busy, protocol_err);
    end
    result_ack = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    result_ack = 1'b0;
    checks++;
    if (busy !== 0 || restart_req !== 0 || result_valid !== 0) begin
      failures++;
      $display("FAIL idle_ack_ignored: busy=%b restart=%b valid=%b expected 0 0 0", busy, restart_req, result_valid);
    end
  endtask

  task automatic test_tie();
    int v [NC] = '{5, -3, 12, 7, 12, 0, 1, 2, 3, 4};
    for (int i = 0; i < NC; i++) words[i] = int2fx(v[i]);
    run_inference("tie", 1'b0, 0);
  endtask

  task automatic test_all_negative();
    for (int i = 0; i < NC; i++) words[i] = int2fx(i - 10);
    run_inference("all_negative", 1'b0, 0);
  endtask

  task automatic test_ack_hold();
    for (int i = 0; i < NC; i++) words[i] = int2fx(int'($urandom_range(0, 40)) - 20);
    run_inference("ack_hold", 1'b0, 20);
  endtask

  task automatic test_back_to_back();
    words[0] = int2fx(100);
    for (int i = 1; i < NC; i++) words[i] = int2fx(int'($urandom_range(0, 50)));
    run_inference("b2b_first", 1'b0, 0);
    for (int i = 0; i < NC; i++) words[i] = int2fx(-20 + i);
    words[NC-1] = int2fx(-1) | DW'(28'h0000123);
    run_inference("b2b_second", 1'b0, 0);
  endtask

  task automatic test_random();
    logic [63:0] r;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NC; i++) begin
        if (n < 3) begin
          words[i] = int2fx(int'($urandom_range(0, 7)) - 4) | DW'($urandom_range(0, 1) << 20);
        end else begin
          r = {$urandom, $urandom};
          words[i] = r[DW-1:0];
        end
      end
      run_inference($sformatf("random%0d", n), 1'b0, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_protocol_err();
    for (int i = 0; i < NC; i++) words[i] = int2fx(int'($urandom_range(0, 30)) - 15);
    auto_xfer = 1'b0;
    run_inference("perr_set", 1'b1, 0);
    auto_xfer = 1'b1;
    for (int i = 0; i < NC; i++) words[i] = int2fx(int'($urandom_range(0, 30)) - 15);
    run_inference("perr_sticky", 1'b1, 0);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < NC; i++) words[i] = int2fx(i);
    wk = 0; pend = 1'b0; shift_cnt = 0;
    layer_transferred = 1'b0;
    layer_done = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    layer_done = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (shift_req !== 0 || restart_req !== 0 || result_valid !== 0 || class_idx !== '0 ||
        max_value !== '0 || busy !== 0 || protocol_err !== 0) begin
      failures++;
      $display("FAIL mid_reset_state: shift=%b restart=%b valid=%b idx=%0d max=%h busy=%b perr=%b expected all 0",
               shift_req, restart_req, result_valid, class_idx, max_value, busy, protocol_err);
    end
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (shift_cnt != 5 || busy !== 0) begin
      failures++;
      $display("FAIL mid_reset_abandon: strobes=%0d busy=%b expected 5 0", shift_cnt, busy);
    end
    for (int i = 0; i < NC; i++) words[i] = int2fx(int'($urandom_range(0, 30)) - 15);
    run_inference("after_mid_reset", 1'b0, 0);
  endtask

  initial begin
    rst = 1'b1;
    layer_done = 1'b0;
    layer_transferred = 1'b0;
    layer_sout = '0;
    result_ack = 1'b0;
    wk = 0; pend = 1'b0; shift_cnt = 0;
    fork
      upstream();
    join_none
    test_reset();
    test_tie();
    test_all_negative();
    test_ack_hold();
    test_back_to_back();
    test_random();
    test_protocol_err();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
